// File: rtl/frame_capture.sv
// 1bpp display-stream grabber: samples every second active pixel, packs LSB-first into 32-bit words, stores them in a single-port RAM read over the bus.
// Latency: control/status read 1 cycle; RAM read 2 cycles, plus 1 cycle for each cycle a pending capture write holds the RAM port.
// Backpressure: capture writes own the RAM port; only one bus read may be outstanding, and any read issued while one is outstanding is dropped.
// Optional feature macro: CAPTURE_LINE_SKIP_EN (capture only every second line).
// Ports: clk_50mhz/rst_n clocking; clk_en_12_5mhz pixel enable; bus_* CPU access (CTRL_BIT selects ctrl/status vs RAM);
//        hsync/vsync/disp_en/pix_in display stream; irq high while a capture is done.
module frame_capture #(
    parameter int          AW           = 13,
    parameter int          CTRL_BIT     = 19,
    parameter logic [31:0] BASE_CAPTURE = 32'h4000_0000
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        clk_en_12_5mhz,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_ren,
    input  logic        bus_wen,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        disp_en,
    input  logic        pix_in,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_FLUSH_WAIT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          start_cap, flush_load, arm_go;
    logic          hsync_d, vsync_d, hs_fall, vs_fall;
    logic          htoggle, line_en, strike;
    logic [4:0]    bit_idx;
    logic [31:0]   pack, wbuf, ram_q, status;
    logic          wr_req, ram_we, overflow;
    logic [AW:0]   wr_addr;
    logic [15:0]   word_cnt;
    logic          region_hit, ctrl_sel, ctrl_wr, arm_cmd, abort_cmd;
    logic          rd_pend, rd_s1, rd_busy, ctrl_rd, ram_rd, rd_issue;
    logic [AW-1:0] rd_addr, rd_issue_addr;
    logic          unused_bits;
    logic [31:0]   mem [0:(1<<AW)-1];

    assign hs_fall = hsync_d & ~hsync;
    assign vs_fall = vsync_d & ~vsync;

    assign region_hit = (bus_addr[31:20] == BASE_CAPTURE[31:20]);
    assign ctrl_sel   = bus_addr[CTRL_BIT];
    assign ctrl_wr    = region_hit & bus_wen & ctrl_sel;
    assign abort_cmd  = ctrl_wr & bus_wdata[1];
    assign arm_cmd    = ctrl_wr & bus_wdata[0] & ~bus_wdata[1];

    // One outstanding read covers both a latched RAM read and one in the RAM stage.
    assign rd_busy       = rd_pend | rd_s1;
    assign ctrl_rd       = region_hit & bus_ren & ctrl_sel & ~rd_busy;
    assign ram_rd        = region_hit & bus_ren & ~ctrl_sel & ~rd_busy;
    assign rd_issue      = (rd_pend | ram_rd) & ~wr_req;
    assign rd_issue_addr = rd_pend ? rd_addr : bus_addr[AW+1:2];

    // wr_addr has one extra bit so a full RAM is visible as wr_addr == 2**AW.
    assign ram_we = wr_req & ~wr_addr[AW];

    // Frame end beats a coincident sample.
    assign strike = clk_en_12_5mhz & disp_en & ~htoggle & line_en
                  & (state == S_CAPTURE) & ~vs_fall;

    assign status = {word_cnt, 13'd0, overflow, (state == S_DONE),
                     (state == S_ARMED) || (state == S_CAPTURE)};
    assign irq    = (state == S_DONE);

    assign unused_bits = ^{bus_addr, bus_wdata};

`ifdef CAPTURE_LINE_SKIP_EN
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n)       line_en <= 1'b1;
        else if (vs_fall) line_en <= 1'b1;
        else if (hs_fall) line_en <= ~line_en;
    end
`else
    assign line_en = 1'b1;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_cap  = 1'b0;
        flush_load = 1'b0;
        arm_go     = 1'b0;
        case (state)
            S_IDLE: if (arm_cmd) begin
                state_nxt = S_ARMED;
                arm_go    = 1'b1;
            end
            S_ARMED: if (vs_fall) begin
                state_nxt = S_CAPTURE;
                start_cap = 1'b1;
            end
            S_CAPTURE: if (vs_fall) state_nxt = S_FLUSH;
            // Let any in-flight full-word write finish before loading the partial word.
            S_FLUSH: if (!wr_req) begin
                if (bit_idx != 5'd0) begin
                    flush_load = 1'b1;
                    state_nxt  = S_FLUSH_WAIT;
                end else begin
                    state_nxt  = S_DONE;
                end
            end
            S_FLUSH_WAIT: if (!wr_req) state_nxt = S_DONE;
            S_DONE: if (arm_cmd) begin
                state_nxt = S_ARMED;
                arm_go    = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_cmd) begin
            state_nxt  = S_IDLE;
            start_cap  = 1'b0;
            flush_load = 1'b0;
            arm_go     = 1'b0;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            hsync_d    <= 1'b0;
            vsync_d    <= 1'b0;
            htoggle    <= 1'b0;
            bit_idx    <= 5'd0;
            pack       <= 32'd0;
            wbuf       <= 32'd0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            word_cnt   <= 16'd0;
            overflow   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_addr    <= '0;
            rd_s1      <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= 32'd0;
        end else begin
            hsync_d <= hsync;
            vsync_d <= vsync;

            if (hs_fall)                             htoggle <= 1'b0;
            else if (clk_en_12_5mhz && disp_en)      htoggle <= ~htoggle;

            if (start_cap) begin
                bit_idx <= 5'd0;
                pack    <= 32'd0;
            end else if (strike) begin
                bit_idx <= bit_idx + 5'd1;
                if (bit_idx == 5'd31) begin
                    wbuf <= {pix_in, pack[30:0]};
                    pack <= 32'd0;
                end else begin
                    pack[bit_idx] <= pix_in;
                end
            end else if (flush_load) begin
                // Unsampled high bits are still zero from the last clear.
                wbuf    <= pack;
                pack    <= 32'd0;
                bit_idx <= 5'd0;
            end

            if ((strike && bit_idx == 5'd31) || flush_load) wr_req <= 1'b1;
            else                                            wr_req <= 1'b0;

            if (wr_req) begin
                if (wr_addr[AW]) begin
                    overflow <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                    if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                end
            end
            if (arm_go) begin
                wr_addr  <= '0;
                word_cnt <= 16'd0;
                overflow <= 1'b0;
            end

            rd_pend <= rd_issue ? 1'b0 : (rd_pend | ram_rd);
            if (ram_rd) rd_addr <= bus_addr[AW+1:2];
            rd_s1      <= rd_issue;
            bus_rvalid <= rd_s1 | ctrl_rd;
            bus_rdata  <= rd_s1 ? ram_q : (ctrl_rd ? status : 32'd0);
        end
    end

    // Single-port RAM: a capture write and a bus read never share a cycle.
    always_ff @(posedge clk_50mhz) begin
        if (ram_we)        mem[wr_addr[AW-1:0]] <= wbuf;
        else if (rd_issue) ram_q <= mem[rd_issue_addr];
    end

endmodule

// File: doc/frame_capture.md
Name: frame_capture

Overview:
- 1bpp display-stream grabber: samples the pixel stream on the display timing, packs pixels into 32-bit words and writes them to an internal single-port RAM.
- CPU arms a capture and reads the result over the system bus.
- Counterpart of the overlay path: overlay turns RAM words into pixels; this block turns pixels into RAM words, using the same packing and decimation.
- Sits beside the overlay on the same bus and display timing signals; used for screen capture and self-test.

Parameters:
- AW, 13, RAM word-address width; depth is 2**AW 32-bit words.
- CTRL_BIT, 19, bus_addr bit that selects the control/status register (1) or RAM (0) inside the block's 1 MB region.

Ports:
- clk_50mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en_12_5mhz  in  1  pixel-clock enable
- bus_addr  in  32  byte address; region is selected when {bus_addr[31:20],20'h0} == BASE_CAPTURE
- bus_wdata  in  32  write data (control register only)
- bus_ren  in  1  single-cycle read strobe
- bus_wen  in  1  single-cycle write strobe
- bus_rdata  out  32  read data
- bus_rvalid  out  1  single-cycle pulse when bus_rdata is valid
- hsync  in  1  horizontal sync; its falling edge starts a line
- vsync  in  1  vertical sync; its falling edge starts a frame
- disp_en  in  1  active-video qualifier
- pix_in  in  1  pixel value to capture
- irq  out  1  level high while done=1

Behaviour:
- Reset: all outputs 0; state IDLE; counters, flags and the pack register cleared. RAM contents are undefined.
- Edge detection: hsync and vsync edges are detected with a 1-cycle registered delay (previous value & ~current).
- htoggle:
  - Cleared on the hsync fall.
  - Toggles on every clk_en_12_5mhz & disp_en.
- Sample strike: clk_en_12_5mhz & disp_en & ~htoggle & line_en & state==CAPTURE.
  - ~htoggle means the first pixel of each line is sampled, then every second pixel after that.
  - line_en is 1 unless CAPTURE_LINE_SKIP_EN is defined.
- Packing:
  - LSB first: the first sampled pixel goes to bit 0.
  - bit_idx (5 bits) is continuous across lines and wraps 31 -> 0.
  - When bit_idx==31 is sampled, the completed word is placed in wbuf and wr_req is set.
- RAM port priority:
  - wr_req has priority. It writes wbuf at wr_addr on the next clk_50mhz cycle, then wr_addr increments and wr_req clears.
  - Bus RAM reads are latched as pending and issued on the first cycle with no wr_req.
  - bus_rdata/bus_rvalid appear 2 cycles after issue, so the unstalled latency from bus_ren to bus_rvalid is 2 cycles.
- Bus accesses:
  - Bus writes to the RAM area are ignored.
  - Control register reads have 1-cycle latency and are never stalled.
  - A read while a previous read is still pending is dropped (one outstanding read only).
- Control register, write:
  - bit0 arm: IDLE/DONE -> ARMED; clears done and overflow; wr_addr=0.
  - bit1 abort: any state -> IDLE; done is not set.
  - abort wins if both bits are set.
- Status register, read:
  - bit0 busy (ARMED or CAPTURE), bit1 done, bit2 overflow.
  - [31:16] words written (saturating at 16'hFFFF).
- States:
  - IDLE -> ARMED on arm.
  - ARMED -> CAPTURE on vsync fall; bit_idx=0, pack register cleared.
  - CAPTURE -> DONE on the next vsync fall. A partial word (bit_idx != 0) is flushed zero-padded in the high bits, and done is set after the flush write completes.
  - DONE -> ARMED on arm, -> IDLE on abort.
- Overflow:
  - A word write attempted when wr_addr == 2**AW is suppressed and overflow is set.
  - Capture continues until the frame end; the word count stops incrementing.
- Simultaneous events:
  - vsync fall and a sample strike in the same cycle: the frame-end transition wins and the sample is discarded.
  - Arm during CAPTURE is ignored.
  - Async reset mid-capture returns to IDLE immediately; no partial write is made.

Optional Feature:
- Macro: CAPTURE_LINE_SKIP_EN.
- Defined: line_en toggles on each hsync fall and is forced to 1 on vsync fall, so lines 0, 2, 4... are captured. This matches the overlay line doubling, and a 640x480 frame yields 320x240.
- Undefined: line_en is constant 1 and every line is captured (320x480).

Test Plan:
- Arm, then a 640x4-active frame with pix_in=1 on odd 12.5 MHz pixels only -> RAM words 0..39 all 32'h0, word count 40, done=1, irq=1 (define off).
- Same stimulus with pix_in alternating 1,0 per sample position -> every word is 32'h55555555; with CAPTURE_LINE_SKIP_EN, word count is 20.
- Frame of 100 sampled pixels all 1 -> words 0..2 = 32'hFFFFFFFF, word 3 = 32'h0000000F, count 4.
- AW=4 (16 words) and a frame of 20 full words -> count 16, overflow=1, done=1; word 15 intact.
- Bus RAM read issued in the same cycle as wr_req -> bus_rvalid after 3 cycles with the correct data; the capture word is still written.
- Abort during CAPTURE, then assert rst_n=0 for 1 cycle mid-frame -> busy=0, done=0, no further RAM writes, status reads 0.
